// File: rtl/hazard_forward_unit_if.sv
// hazard_forward_unit_if: pipeline-side bundle between ID/EX/MEM stage state and the hazard/forward unit.
interface hazard_forward_unit_if #(parameter int REGW = 4);
  logic [REGW-1:0] ID_Rs, ID_Rt, EX_Rd, MEM_Rd;
  logic ID_UsesRs, ID_UsesRt, ID_IsMulDiv, ID_ReadsHiLo;
  logic EX_RegWrite, EX_MemRead, EX_Branch, CompareFlag;
  logic MEM_RegWrite, MemWait;
  logic [1:0] ForwardA, ForwardB;
  logic FrezePC, FrezeIFID, FrezeIDEX_SH, FlushIFID, FlushIDEX, HiLoBusy;
  modport master (
    output ID_Rs, ID_Rt, EX_Rd, MEM_Rd, ID_UsesRs, ID_UsesRt, ID_IsMulDiv, ID_ReadsHiLo,
           EX_RegWrite, EX_MemRead, EX_Branch, CompareFlag, MEM_RegWrite, MemWait,
    input  ForwardA, ForwardB, FrezePC, FrezeIFID, FrezeIDEX_SH, FlushIFID, FlushIDEX, HiLoBusy
  );
  modport slave (
    input  ID_Rs, ID_Rt, EX_Rd, MEM_Rd, ID_UsesRs, ID_UsesRt, ID_IsMulDiv, ID_ReadsHiLo,
           EX_RegWrite, EX_MemRead, EX_Branch, CompareFlag, MEM_RegWrite, MemWait,
    output ForwardA, ForwardB, FrezePC, FrezeIFID, FrezeIDEX_SH, FlushIFID, FlushIDEX, HiLoBusy
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: registered EX forwarding selects plus combinational freeze/flush control
// for load-use, HI/LO-busy, taken-branch and memory-wait conditions.
module hazard_forward_unit #(
  parameter int MULDIV_CYCLES = 4,
  parameter int REGW = 4
) (
  input logic clk,
  input logic rest,
  hazard_forward_unit_if.slave hif
);
  localparam logic [3:0] LOAD = 4'(MULDIV_CYCLES);
  logic [3:0] r_cnt;
  logic [1:0] r_fwd_a, r_fwd_b;
  logic w_busy, w_taken, w_load_use, w_hilo_haz, w_stall, w_flush_idex, w_issue;
  logic [1:0] w_fwd_a, w_fwd_b;
  function automatic logic [1:0] fwd_sel(input logic [REGW-1:0] src, input logic uses,
                                         input logic exw, input logic [REGW-1:0] exrd,
                                         input logic memw, input logic [REGW-1:0] memrd);
    return (!uses || src == '0) ? 2'b00 :
           (exw && exrd == src) ? 2'b10 :
           (memw && memrd == src) ? 2'b01 : 2'b00;
  endfunction
  always_comb begin
    w_busy = r_cnt != '0;
    w_taken = hif.EX_Branch & hif.CompareFlag;
    w_load_use = hif.EX_MemRead & (hif.EX_Rd != '0) &
                 ((hif.ID_UsesRs & (hif.ID_Rs == hif.EX_Rd)) | (hif.ID_UsesRt & (hif.ID_Rt == hif.EX_Rd)));
    w_hilo_haz = w_busy & (hif.ID_ReadsHiLo | hif.ID_IsMulDiv);
    w_stall = (w_load_use | w_hilo_haz) & ~w_taken;
    w_flush_idex = ~hif.MemWait & (w_taken | w_stall);
    w_issue = hif.ID_IsMulDiv & ~hif.MemWait & ~w_taken & ~w_stall;
    w_fwd_a = fwd_sel(hif.ID_Rs, hif.ID_UsesRs, hif.EX_RegWrite, hif.EX_Rd, hif.MEM_RegWrite, hif.MEM_Rd);
    w_fwd_b = fwd_sel(hif.ID_Rt, hif.ID_UsesRt, hif.EX_RegWrite, hif.EX_Rd, hif.MEM_RegWrite, hif.MEM_Rd);
    hif.FrezePC = hif.MemWait | w_stall;
    hif.FrezeIFID = hif.MemWait | w_stall;
    hif.FrezeIDEX_SH = hif.MemWait;
    hif.FlushIFID = ~hif.MemWait & w_taken;
    hif.FlushIDEX = w_flush_idex;
    hif.HiLoBusy = w_busy;
    hif.ForwardA = r_fwd_a;
    hif.ForwardB = r_fwd_b;
  end
  // The busy counter ignores MemWait so HI/LO latency is measured in real cycles.
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      r_cnt <= '0;
      r_fwd_a <= 2'b00;
      r_fwd_b <= 2'b00;
    end else begin
      r_cnt <= w_issue ? LOAD : r_cnt - 4'(w_busy);
      r_fwd_a <= hif.MemWait ? r_fwd_a : w_flush_idex ? 2'b00 : w_fwd_a;
      r_fwd_b <= hif.MemWait ? r_fwd_b : w_flush_idex ? 2'b00 : w_fwd_b;
    end
  end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed vectors with literal expectations plus a per-cycle
// comparison against a cycle-time based behavioural model.
module tb_hazard_forward_unit;
  localparam int MULDIV = 4;
  logic clk, rest;
  int checks = 0, failures = 0;
  hazard_forward_unit_if #(.REGW(4)) bus ();
  hazard_forward_unit #(.MULDIV_CYCLES(MULDIV), .REGW(4)) dut (.clk(clk), .rest(rest), .hif(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask
  // Model: HI/LO becomes ready at an absolute cycle number; the cycle's action is one of
  // none / hold-all / branch-flush / bubble, and every output is read off that action.
  localparam int A_NONE = 0, A_HOLD = 1, A_BRANCH = 2, A_BUBBLE = 3;
  int cyc = 0, m_ready = 0, m_act;
  logic [1:0] m_fa, m_fb;
  logic m_busy;
  function automatic logic [1:0] producer(input logic [3:0] src, input logic uses);
    logic [3:0] rd [2];
    logic wr [2];
    rd[0] = bus.EX_Rd; wr[0] = bus.EX_RegWrite;
    rd[1] = bus.MEM_Rd; wr[1] = bus.MEM_RegWrite;
    if (!uses || src == 0) return 2'b00;
    for (int k = 0; k < 2; k++) if (wr[k] && rd[k] == src) return k == 0 ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction
  always_comb begin
    m_busy = cyc < m_ready;
    m_act = A_NONE;
    if (bus.MemWait) m_act = A_HOLD;
    else if (bus.EX_Branch && bus.CompareFlag) m_act = A_BRANCH;
    else if ((bus.EX_MemRead && bus.EX_Rd != 0 &&
              ((bus.ID_UsesRs && bus.ID_Rs == bus.EX_Rd) || (bus.ID_UsesRt && bus.ID_Rt == bus.EX_Rd))) ||
             (m_busy && (bus.ID_ReadsHiLo || bus.ID_IsMulDiv))) m_act = A_BUBBLE;
  end
  always @(posedge clk or negedge rest) begin
    if (!rest) begin
      m_fa <= 2'b00;
      m_fb <= 2'b00;
      m_ready <= 0;
    end else begin
      cyc <= cyc + 1;
      if (m_act != A_HOLD) begin
        m_fa <= (m_act == A_NONE) ? producer(bus.ID_Rs, bus.ID_UsesRs) : 2'b00;
        m_fb <= (m_act == A_NONE) ? producer(bus.ID_Rt, bus.ID_UsesRt) : 2'b00;
      end
      if (m_act == A_NONE && bus.ID_IsMulDiv) m_ready <= cyc + 1 + MULDIV;
    end
  end
  always @(negedge clk) begin
    chk("model_ForwardA", 8'(bus.ForwardA), 8'(m_fa));
    chk("model_ForwardB", 8'(bus.ForwardB), 8'(m_fb));
    chk("model_HiLoBusy", 8'(bus.HiLoBusy), 8'(m_busy));
    chk("model_FrezePC", 8'(bus.FrezePC), 8'(m_act == A_HOLD || m_act == A_BUBBLE));
    chk("model_FrezeIFID", 8'(bus.FrezeIFID), 8'(m_act == A_HOLD || m_act == A_BUBBLE));
    chk("model_FrezeIDEX", 8'(bus.FrezeIDEX_SH), 8'(m_act == A_HOLD));
    chk("model_FlushIFID", 8'(bus.FlushIFID), 8'(m_act == A_BRANCH));
    chk("model_FlushIDEX", 8'(bus.FlushIDEX), 8'(m_act == A_BRANCH || m_act == A_BUBBLE));
  end
  task automatic idle();
    {bus.ID_Rs, bus.ID_Rt, bus.EX_Rd, bus.MEM_Rd} = '0;
    {bus.ID_UsesRs, bus.ID_UsesRt, bus.ID_IsMulDiv, bus.ID_ReadsHiLo} = '0;
    {bus.EX_RegWrite, bus.EX_MemRead, bus.EX_Branch, bus.CompareFlag} = '0;
    {bus.MEM_RegWrite, bus.MemWait} = '0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int stalls;
    idle();
    rest = 1'b0;
    #12;
    chk("rst_ForwardA", 8'(bus.ForwardA), 8'd0);
    chk("rst_ForwardB", 8'(bus.ForwardB), 8'd0);
    chk("rst_HiLoBusy", 8'(bus.HiLoBusy), 8'd0);
    chk("rst_FrezePC", 8'(bus.FrezePC), 8'd0);
    step();
    rest = 1'b1;
    step();
    // T1: EX forward to operand A
    bus.ID_Rs = 3; bus.ID_UsesRs = 1; bus.EX_Rd = 3; bus.EX_RegWrite = 1;
    #1 chk("t1_no_freeze", 8'(bus.FrezePC), 8'd0);
    step();
    chk("t1_ForwardA", 8'(bus.ForwardA), 8'd2);
    // T2: EX beats MEM; register 0 never forwarded; MEM-only match
    idle();
    bus.ID_Rt = 5; bus.ID_UsesRt = 1; bus.EX_Rd = 5; bus.EX_RegWrite = 1; bus.MEM_Rd = 5; bus.MEM_RegWrite = 1;
    step();
    chk("t2_ForwardB_ex", 8'(bus.ForwardB), 8'd2);
    bus.ID_Rt = 0; bus.EX_Rd = 0; bus.MEM_Rd = 0;
    step();
    chk("t2_ForwardB_r0", 8'(bus.ForwardB), 8'd0);
    bus.ID_Rt = 7; bus.EX_Rd = 6; bus.MEM_Rd = 7;
    step();
    chk("t2_ForwardB_mem", 8'(bus.ForwardB), 8'd1);
    bus.ID_UsesRt = 0;
    step();
    chk("t2_ForwardB_unused", 8'(bus.ForwardB), 8'd0);
    // T3: load-use bubble, then MEM forward
    idle();
    bus.EX_MemRead = 1; bus.EX_RegWrite = 1; bus.EX_Rd = 4; bus.ID_Rt = 4; bus.ID_UsesRt = 1;
    #1;
    chk("t3_FrezePC", 8'(bus.FrezePC), 8'd1);
    chk("t3_FrezeIFID", 8'(bus.FrezeIFID), 8'd1);
    chk("t3_FlushIDEX", 8'(bus.FlushIDEX), 8'd1);
    chk("t3_FrezeIDEX", 8'(bus.FrezeIDEX_SH), 8'd0);
    step();
    chk("t3_ForwardB_bubble", 8'(bus.ForwardB), 8'd0);
    bus.EX_MemRead = 0; bus.EX_RegWrite = 0; bus.EX_Rd = 0; bus.MEM_Rd = 4; bus.MEM_RegWrite = 1;
    #1 chk("t3_released", 8'(bus.FrezePC), 8'd0);
    step();
    chk("t3_ForwardB_mem", 8'(bus.ForwardB), 8'd1);
    // T4: mul/div issue then HI/LO reader stalls exactly MULDIV cycles
    idle();
    bus.ID_IsMulDiv = 1;
    #1 chk("t4_issue_no_flush", 8'(bus.FlushIDEX), 8'd0);
    step();
    bus.ID_IsMulDiv = 0; bus.ID_ReadsHiLo = 1;
    stalls = 0;
    for (int i = 0; i < 10 && bus.HiLoBusy; i++) begin
      chk("t4_stall", 8'(bus.FrezePC), 8'd1);
      stalls++;
      step();
    end
    chk("t4_busy_cycles", 8'(stalls), 8'(MULDIV));
    chk("t4_release", 8'(bus.FrezePC), 8'd0);
    // A mul/div held by a load-use never starts the counter
    idle();
    bus.ID_IsMulDiv = 1; bus.EX_MemRead = 1; bus.EX_Rd = 1; bus.ID_Rs = 1; bus.ID_UsesRs = 1;
    step();
    chk("stalled_muldiv_idle", 8'(bus.HiLoBusy), 8'd0);
    // T5: taken branch outranks load-use
    idle();
    bus.EX_Branch = 1; bus.CompareFlag = 1; bus.EX_MemRead = 1; bus.EX_RegWrite = 1;
    bus.EX_Rd = 2; bus.ID_Rs = 2; bus.ID_UsesRs = 1;
    #1;
    chk("t5_FlushIFID", 8'(bus.FlushIFID), 8'd1);
    chk("t5_FlushIDEX", 8'(bus.FlushIDEX), 8'd1);
    chk("t5_FrezePC", 8'(bus.FrezePC), 8'd0);
    step();
    chk("t5_ForwardA", 8'(bus.ForwardA), 8'd0);
    bus.CompareFlag = 0;
    #1 chk("t5_not_taken_stall", 8'(bus.FrezePC), 8'd1);
    // T6: MemWait holds everything while HI/LO counter keeps running; async reset clears it
    idle();
    bus.ID_Rs = 3; bus.ID_UsesRs = 1; bus.EX_Rd = 3; bus.EX_RegWrite = 1; bus.ID_IsMulDiv = 1;
    step();
    chk("t6_ForwardA_set", 8'(bus.ForwardA), 8'd2);
    bus.ID_IsMulDiv = 0; bus.EX_RegWrite = 0; bus.MemWait = 1; bus.EX_Branch = 1; bus.CompareFlag = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t6_FrezePC", 8'(bus.FrezePC), 8'd1);
      chk("t6_FrezeIDEX", 8'(bus.FrezeIDEX_SH), 8'd1);
      chk("t6_no_flush", 8'(bus.FlushIFID), 8'd0);
      step();
      chk("t6_ForwardA_held", 8'(bus.ForwardA), 8'd2);
    end
    chk("t6_still_busy", 8'(bus.HiLoBusy), 8'd1);
    idle();
    #1 rest = 1'b0;
    #1;
    chk("t6_reset_busy", 8'(bus.HiLoBusy), 8'd0);
    chk("t6_reset_fwd", 8'(bus.ForwardA), 8'd0);
    step();
    rest = 1'b1;
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
